// File: rtl/pipe_hazard_unit.sv
// Hazard controller for the 5-stage pipeline. Tracks EX/MEM/WB destinations
// in a three-entry scoreboard and derives forwarding selects, load-use
// stalls, branch flushes and freeze control. Also counts PC-hold cycles.
module pipe_hazard_unit #(
  parameter int REG_AW       = 5,
  parameter int BRANCH_STAGE = 3,
  parameter int CNT_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              br_taken,
  input  logic              mem_busy,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              pipe_freeze,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              ex_valid, ex_reg_write, ex_mem_read;
  logic [REG_AW-1:0] ex_dest, ex_rs, ex_rt;
  logic              mem_valid, mem_reg_write, mem_mem_read;
  logic [REG_AW-1:0] mem_dest;
  logic              wb_valid, wb_reg_write, wb_mem_read;
  logic [REG_AW-1:0] wb_dest;

  logic load_use;
  logic mem_wr_ok, wb_wr_ok;

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use = ex_valid && ex_mem_read && (ex_dest != '0) && id_valid &&
               ((id_use_rs && (id_rs == ex_dest)) ||
                (id_use_rt && (id_rt == ex_dest)));
  end

  // Freeze beats branch, branch beats load-use; reset masks everything.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_freeze = 1'b0;
    if (!reset) begin
      if (mem_busy) begin
        pipe_freeze = 1'b1;
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
      end else if (br_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = (BRANCH_STAGE == 3);
      end else if (load_use) begin
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  // Operand forwarding: the younger producer (MEM) wins over WB.
  always_comb begin
    mem_wr_ok = mem_valid && mem_reg_write && (mem_dest != '0);
    wb_wr_ok  = wb_valid && wb_reg_write && (wb_dest != '0);
    fwd_a     = 2'b00;
    fwd_b     = 2'b00;
    if (!reset && ex_valid) begin
      if (mem_wr_ok && (mem_dest == ex_rs))     fwd_a = 2'b01;
      else if (wb_wr_ok && (wb_dest == ex_rs))  fwd_a = 2'b10;
      if (mem_wr_ok && (mem_dest == ex_rt))     fwd_b = 2'b01;
      else if (wb_wr_ok && (wb_dest == ex_rt))  fwd_b = 2'b10;
    end
  end

  // Scoreboard shifts alongside the pipeline registers; holds on freeze.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
      wb_valid  <= 1'b0;
    end else if (!pipe_freeze) begin
      wb_valid      <= mem_valid;
      wb_dest       <= mem_dest;
      wb_reg_write  <= mem_reg_write;
      wb_mem_read   <= mem_mem_read;
      mem_valid     <= ex_valid && !exmem_flush;
      mem_dest      <= ex_dest;
      mem_reg_write <= ex_reg_write;
      mem_mem_read  <= ex_mem_read;
      ex_valid      <= id_valid && !idex_flush;
      ex_dest       <= id_dest;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
    end
  end

  // Saturating count of cycles the PC was held.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (pc_hold && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: two instances (branch in MEM with a 4-bit
// counter, branch in EX with a 16-bit counter) share one directed stimulus
// stream and are checked every cycle against an instruction-level model.
module tb_pipe_hazard_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic       br_taken, mem_busy;

  logic       pc_hold_w     [2];
  logic       ifid_hold_w   [2];
  logic       ifid_flush_w  [2];
  logic       idex_flush_w  [2];
  logic       exmem_flush_w [2];
  logic       pipe_freeze_w [2];
  logic [1:0] fwd_a_w       [2];
  logic [1:0] fwd_b_w       [2];
  logic [3:0]  cnt0;
  logic [15:0] cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  pipe_hazard_unit #(.REG_AW(5), .BRANCH_STAGE(3), .CNT_W(4)) dut0 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .br_taken(br_taken),
    .mem_busy(mem_busy), .pc_hold(pc_hold_w[0]), .ifid_hold(ifid_hold_w[0]),
    .ifid_flush(ifid_flush_w[0]), .idex_flush(idex_flush_w[0]),
    .exmem_flush(exmem_flush_w[0]), .pipe_freeze(pipe_freeze_w[0]),
    .fwd_a(fwd_a_w[0]), .fwd_b(fwd_b_w[0]), .stall_cnt(cnt0));

  pipe_hazard_unit #(.REG_AW(5), .BRANCH_STAGE(2), .CNT_W(16)) dut1 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .br_taken(br_taken),
    .mem_busy(mem_busy), .pc_hold(pc_hold_w[1]), .ifid_hold(ifid_hold_w[1]),
    .ifid_flush(ifid_flush_w[1]), .idex_flush(idex_flush_w[1]),
    .exmem_flush(exmem_flush_w[1]), .pipe_freeze(pipe_freeze_w[1]),
    .fwd_a(fwd_a_w[1]), .fwd_b(fwd_b_w[1]), .stall_cnt(cnt1));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit v; int dest; bit rw; bit mr; int rs; int rt;
  } instr_t;

  instr_t in_flight [2][3];        // per instance: [0]=EX [1]=MEM [2]=WB
  int     m_cnt     [2] = '{0, 0};
  int     cnt_max   [2] = '{15, 65535};
  int     br_stage  [2] = '{3, 2};

  // Which older instruction supplies register src: 1 = MEM, 2 = WB, 0 = none.
  function automatic int producer(input int inst, input int src);
    for (int k = 1; k <= 2; k++)
      if (in_flight[inst][k].v && in_flight[inst][k].rw &&
          in_flight[inst][k].dest != 0 && in_flight[inst][k].dest == src)
        return k;
    return 0;
  endfunction

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      instr_t ex;
      bit lu, frz, br, e_pc, e_iflush, e_dflush, e_mflush;
      int e_fa, e_fb, act_cnt;
      ex  = in_flight[i][0];
      lu  = ex.v && ex.mr && ex.dest != 0 && id_valid &&
            ((id_use_rs && int'(id_rs) == ex.dest) || (id_use_rt && int'(id_rt) == ex.dest));
      frz = !reset && mem_busy;
      br  = !reset && !mem_busy && br_taken;
      lu  = !reset && !mem_busy && !br_taken && lu;
      e_pc     = frz || lu;
      e_iflush = br;
      e_dflush = br || lu;
      e_mflush = br && (br_stage[i] == 3);
      e_fa = (!reset && ex.v) ? producer(i, ex.rs) : 0;
      e_fb = (!reset && ex.v) ? producer(i, ex.rt) : 0;
      act_cnt = (i == 0) ? int'(cnt0) : int'(cnt1);

      chk($sformatf("pc_hold[%0d]", i),     int'(pc_hold_w[i]),     int'(e_pc));
      chk($sformatf("ifid_hold[%0d]", i),   int'(ifid_hold_w[i]),   int'(e_pc));
      chk($sformatf("ifid_flush[%0d]", i),  int'(ifid_flush_w[i]),  int'(e_iflush));
      chk($sformatf("idex_flush[%0d]", i),  int'(idex_flush_w[i]),  int'(e_dflush));
      chk($sformatf("exmem_flush[%0d]", i), int'(exmem_flush_w[i]), int'(e_mflush));
      chk($sformatf("pipe_freeze[%0d]", i), int'(pipe_freeze_w[i]), int'(frz));
      chk($sformatf("fwd_a[%0d]", i),       int'(fwd_a_w[i]),       e_fa);
      chk($sformatf("fwd_b[%0d]", i),       int'(fwd_b_w[i]),       e_fb);
      chk($sformatf("stall_cnt[%0d]", i),   act_cnt,                m_cnt[i]);

      // state after the coming rising edge (inputs are stable until then)
      if (reset) begin
        for (int k = 0; k < 3; k++) in_flight[i][k].v = 0;
        m_cnt[i] = 0;
      end else begin
        if (e_pc && m_cnt[i] < cnt_max[i]) m_cnt[i]++;
        if (!frz) begin
          in_flight[i][2]   = in_flight[i][1];
          in_flight[i][1]   = in_flight[i][0];
          in_flight[i][1].v = in_flight[i][0].v && !e_mflush;
          in_flight[i][0]   = '{v: id_valid && !e_dflush, dest: int'(id_dest),
                                rw: id_reg_write, mr: id_mem_read,
                                rs: int'(id_rs), rt: int'(id_rt)};
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_id(input bit v, input int rs, input int rt, input bit urs,
                          input bit urt, input int dest, input bit rw, input bit mr);
    id_valid     = v;
    id_rs        = rs[4:0];
    id_rt        = rt[4:0];
    id_use_rs    = urs;
    id_use_rt    = urt;
    id_dest      = dest[4:0];
    id_reg_write = rw;
    id_mem_read  = mr;
  endtask

  task automatic nop();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic flush();
    nop();
    repeat (3) next();
  endtask

  initial begin
    reset = 1'b1; br_taken = 1'b0; mem_busy = 1'b1;
    nop();
    next();
    @(negedge clock);
    chk("rst_pipe_freeze", int'(pipe_freeze_w[0]), 0);
    chk("rst_pc_hold", int'(pc_hold_w[1]), 0);
    next();
    mem_busy = 1'b0;
    next();
    reset = 1'b0;
    next();

    // load-use: lw r5 then add using r5
    drive_id(1, 1, 0, 1, 0, 5, 1, 1);
    next();
    drive_id(1, 5, 0, 1, 0, 6, 1, 0);
    @(negedge clock);
    chk("lu_pc_hold", int'(pc_hold_w[0]), 1);
    chk("lu_ifid_hold", int'(ifid_hold_w[1]), 1);
    chk("lu_idex_flush", int'(idex_flush_w[0]), 1);
    next();
    @(negedge clock);
    chk("lu_clear", int'(pc_hold_w[0]), 0);
    next();
    nop();
    @(negedge clock);
    chk("lu_fwd_a_wb", int'(fwd_a_w[0]), 2);
    next();
    flush();

    // back-to-back ALU dependence -> MEM forward
    drive_id(1, 1, 2, 1, 1, 3, 1, 0);
    next();
    drive_id(1, 3, 3, 1, 1, 4, 1, 0);
    next();
    nop();
    @(negedge clock);
    chk("alu_fwd_a_mem", int'(fwd_a_w[0]), 1);
    chk("alu_fwd_b_mem", int'(fwd_b_w[1]), 1);
    next();
    flush();

    // one bubble between -> WB forward
    drive_id(1, 1, 2, 1, 1, 3, 1, 0);
    next();
    nop();
    next();
    drive_id(1, 3, 3, 1, 1, 4, 1, 0);
    next();
    nop();
    @(negedge clock);
    chk("gap_fwd_a_wb", int'(fwd_a_w[1]), 2);
    chk("gap_fwd_b_wb", int'(fwd_b_w[0]), 2);
    next();
    flush();

    // MEM and WB both write r7 -> MEM wins
    drive_id(1, 1, 0, 1, 0, 7, 1, 0);
    next();
    drive_id(1, 1, 0, 1, 0, 7, 1, 0);
    next();
    drive_id(1, 7, 2, 1, 1, 8, 1, 0);
    next();
    nop();
    @(negedge clock);
    chk("r7_fwd_a_mem", int'(fwd_a_w[0]), 1);
    chk("r7_fwd_b_none", int'(fwd_b_w[0]), 0);
    next();
    flush();

    // r0 is never a hazard source
    drive_id(1, 1, 0, 1, 0, 0, 1, 1);
    next();
    drive_id(1, 0, 0, 1, 1, 9, 1, 0);
    @(negedge clock);
    chk("r0_no_stall", int'(pc_hold_w[0]), 0);
    next();
    nop();
    @(negedge clock);
    chk("r0_fwd_a", int'(fwd_a_w[0]), 0);
    chk("r0_fwd_b", int'(fwd_b_w[1]), 0);
    next();
    flush();

    // taken branch together with a load-use condition
    drive_id(1, 1, 0, 1, 0, 5, 1, 1);
    next();
    drive_id(1, 5, 0, 1, 0, 6, 1, 0);
    br_taken = 1'b1;
    @(negedge clock);
    chk("br_ifid_flush", int'(ifid_flush_w[0]), 1);
    chk("br_idex_flush", int'(idex_flush_w[0]), 1);
    chk("br3_exmem_flush", int'(exmem_flush_w[0]), 1);
    chk("br_pc_hold", int'(pc_hold_w[0]), 0);
    chk("br_ifid_hold", int'(ifid_hold_w[1]), 0);
    chk("br2_exmem_flush", int'(exmem_flush_w[1]), 0);
    next();
    br_taken = 1'b0;
    flush();

    // freeze for three cycles on top of a load-use stall
    drive_id(1, 1, 0, 1, 0, 5, 1, 1);
    next();
    drive_id(1, 5, 0, 1, 0, 6, 1, 0);
    mem_busy = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("frz_pipe_freeze", int'(pipe_freeze_w[0]), 1);
      chk("frz_idex_flush", int'(idex_flush_w[1]), 0);
      next();
    end
    mem_busy = 1'b0;
    @(negedge clock);
    chk("frz_lu_kept", int'(idex_flush_w[0]), 1);
    next();
    @(negedge clock);
    chk("frz_cnt0", int'(cnt0), 5);
    chk("frz_cnt1", int'(cnt1), 5);
    flush();

    // long hold: saturation of the 4-bit counter, then reset mid-freeze
    mem_busy = 1'b1;
    repeat (20) next();
    @(negedge clock);
    chk("sat_cnt0", int'(cnt0), 15);
    chk("sat_cnt1", int'(cnt1), 25);
    next();
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_pc_hold", int'(pc_hold_w[0]), 0);
    chk("rst_mid_freeze", int'(pipe_freeze_w[1]), 0);
    chk("rst_mid_ifid_hold", int'(ifid_hold_w[0]), 0);
    next();
    @(negedge clock);
    chk("rst_cnt0", int'(cnt0), 0);
    chk("rst_cnt1", int'(cnt1), 0);
    reset = 1'b0;
    mem_busy = 1'b0;
    next();
    next();
    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard controller for the 5-stage pipeline. It owns a small scoreboard of in-flight EX/MEM/WB destinations.
- From that scoreboard it generates EX-operand forwarding selects, load-use stalls, branch flushes and global freeze handling. A saturating stall-cycle counter is included for profiling.
- It sits beside the IF2ID/ID2EXE/EXE2MEM/MEM2WB registers and drives their hold/flush controls and the EX operand muxes.

Parameters:
- REG_AW, 5, register-address width; address 0 is hardwired zero and never a hazard source.
- BRANCH_STAGE, 3, stage where a taken branch resolves: 2 = EX, 3 = MEM.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  ID source register 1.
- id_rt  in  REG_AW  ID source register 2.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_dest  in  REG_AW  ID destination, already muxed rt/rd.
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- br_taken  in  1  taken branch resolved in BRANCH_STAGE this cycle.
- mem_busy  in  1  data memory not ready; freeze the whole pipe.
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  IF2ID keeps its contents.
- ifid_flush  out  1  IF2ID loads a bubble.
- idex_flush  out  1  ID2EXE loads a bubble.
- exmem_flush  out  1  EXE2MEM loads a bubble.
- pipe_freeze  out  1  all pipeline registers hold.
- fwd_a  out  2  EX operand A select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB write data.
- fwd_b  out  2  EX operand B select, same encoding as fwd_a.
- stall_cnt  out  CNT_W  cycles with pc_hold=1 since reset; saturates at all-ones.

Behaviour:
- Scoreboard: three entries EX, MEM, WB. Each holds {valid, dest, reg_write, mem_read}; EX additionally holds rs and rt.
- Advance rule, evaluated at the clock edge:
  - Freeze: everything holds.
  - Otherwise WB<=MEM.
  - MEM<=EX, or invalid if exmem_flush.
  - EX<=ID, or invalid if idex_flush or the ID instruction is not advancing.
- Load-use hazard: EX.valid and EX.mem_read and EX.dest != 0 and id_valid, and either (id_use_rs and id_rs==EX.dest) or (id_use_rt and id_rt==EX.dest).
  - Response: pc_hold=1, ifid_hold=1, idex_flush=1, giving exactly one bubble.
- Branch flush when br_taken=1:
  - ifid_flush=1 and idex_flush=1.
  - If BRANCH_STAGE=3, also exmem_flush=1.
  - pc_hold=0 and ifid_hold=0, so PC loads the target.
  - Branch flush beats load-use; the load-use stall is suppressed that cycle.
- Freeze: mem_busy=1 gives pipe_freeze=1, pc_hold=1, ifid_hold=1 and all flush outputs 0.
  - br_taken is ignored during freeze; the upstream stage holds it stable until freeze releases.
- Forwarding for operand A (B identical using EX.rt):
  - Priority 1: MEM.valid and MEM.reg_write and MEM.dest!=0 and MEM.dest==EX.rs gives 01.
  - Priority 2: else the same test on WB gives 10.
  - Else 00.
  - fwd_a/fwd_b are 00 whenever EX is invalid.
- Hazard, flush and forward outputs are combinational from scoreboard state and current inputs. Scoreboard and counter are registered.
- stall_cnt increments by 1 at each edge where pc_hold=1 and reset=0; it holds at 2^CNT_W-1.
- Reset:
  - At the edge with reset=1: all valid bits <=0 and stall_cnt<=0.
  - While reset is high, every hold/flush/freeze output is forced 0 and fwd_a=fwd_b=00.
  - Reset mid-stall or mid-freeze drops the stall/freeze immediately.
- Latency: hazards are detected in the same cycle the dependent instruction sits in ID; forwarding is valid in the same cycle the consumer sits in EX.

Test Plan:
- lw r5 in EX, ID uses rs=5 -> pc_hold=ifid_hold=idex_flush=1 for exactly one cycle; next cycle hazard clears and fwd_a=10 when the consumer reaches EX.
- add r3 followed by sub using rs=3,rt=3 -> fwd_a=fwd_b=01 in the sub's EX cycle; with one nop between them -> 10.
- MEM and WB both write r7, EX reads r7 -> fwd=01 (MEM wins). Any instruction writing r0 -> fwd=00 and no stall.
- BRANCH_STAGE=3, br_taken=1 coincident with a load-use condition -> ifid_flush=idex_flush=exmem_flush=1, pc_hold=0. With BRANCH_STAGE=2 -> exmem_flush=0.
- mem_busy=1 for 3 cycles during a load-use stall -> pipe_freeze=1, flushes 0, scoreboard unchanged; stall_cnt rises by 3, then by 1 more for the load-use cycle after release.
- CNT_W=4, hold pc_hold for 20 cycles -> stall_cnt saturates at 15. Assert reset mid-stall -> outputs 0 in that cycle and stall_cnt=0 after the edge.
